// File: rtl/alu_core.sv
// RV32I execute-stage ALU: eleven operations selected by ALUSel_i.
// The combinational result and its zero flag are held in one output register stage.

package alu_core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_sel_e;

endpackage : alu_core_pkg

module alu_core
   import alu_core_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            ALUSel_i,
   input  logic [DATA_WIDTH-1:0] alu_operand1_i,
   input  logic [DATA_WIDTH-1:0] alu_operand2_i,
   output logic [DATA_WIDTH-1:0] alu_result_o,
   output logic                  alu_zero_o
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] result_d, result_q;
   logic                  zero_d,   zero_q;
   logic [SHAMT_W-1:0]    shamt;
   logic                  lt_signed;
   logic                  lt_unsigned;
   alu_sel_e              alu_sel;

   // Only the low log2(DATA_WIDTH) bits of operand B form the shift amount.
   assign shamt       = alu_operand2_i[SHAMT_W-1:0];
   assign lt_signed   = $signed(alu_operand1_i) < $signed(alu_operand2_i);
   assign lt_unsigned = alu_operand1_i < alu_operand2_i;
   assign alu_sel     = alu_sel_e'(ALUSel_i);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      result_d = '0;
      case (alu_sel)
         ALU_ADD:    result_d = alu_operand1_i + alu_operand2_i;
         ALU_SUB:    result_d = alu_operand1_i - alu_operand2_i;
         ALU_SLL:    result_d = alu_operand1_i << shamt;
         ALU_SLT:    result_d = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
         ALU_SLTU:   result_d = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
         ALU_XOR:    result_d = alu_operand1_i ^ alu_operand2_i;
         ALU_SRL:    result_d = alu_operand1_i >> shamt;
         ALU_SRA:    result_d = $unsigned($signed(alu_operand1_i) >>> shamt);
         ALU_OR:     result_d = alu_operand1_i | alu_operand2_i;
         ALU_AND:    result_d = alu_operand1_i & alu_operand2_i;
         ALU_PASS_B: result_d = alu_operand2_i;
         default:    result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign alu_result_o = result_q;
   assign alu_zero_o   = zero_q;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases, back-to-back stream with mid-stream
// reset, then random operations compared against an arithmetic reference model.

module tb_alu_core;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   sel;
   logic [W-1:0] op_a, op_b;
   logic [W-1:0] alu_result;
   logic         alu_zero;

   int n_checks = 0;
   int n_errors = 0;

   alu_core #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ALUSel_i       (sel),
      .alu_operand1_i (op_a),
      .alu_operand2_i (op_b),
      .alu_result_o   (alu_result),
      .alu_zero_o     (alu_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model built from the operation definitions using 64-bit arithmetic.
   function automatic logic [W-1:0] ref_alu(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint unsigned mask = 64'hFFFF_FFFF;
      int sh = int'(b % 32);
      longint sa = (a[31]) ? longint'(ua) - 64'sh1_0000_0000 : longint'(ua);
      longint sb = (b[31]) ? longint'(ub) - 64'sh1_0000_0000 : longint'(ub);
      longint unsigned fill;
      case (s)
         0:  return W'((ua + ub) & mask);
         1:  return W'((ua + (mask + 1) - ub) & mask);
         2:  return W'((ua * (64'd1 << sh)) & mask);
         3:  return (sa < sb) ? 32'd1 : 32'd0;
         4:  return (ua < ub) ? 32'd1 : 32'd0;
         5:  return a ^ b;
         6:  return W'(ua / (64'd1 << sh));
         7: begin
            fill = a[31] ? (mask & ~(mask >> sh)) : 64'd0;
            return W'((ua / (64'd1 << sh)) | fill);
         end
         8:  return a | b;
         9:  return a & b;
         10: return b;
         default: return '0;
      endcase
   endfunction

   // Present one operation, clock it, and check both outputs one cycle later.
   task automatic run_op(input string tag, input int s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] exp;
      exp  = ref_alu(s, a, b);
      sel  = 4'(s);
      op_a = a;
      op_b = b;
      @(posedge clk);
      #1;
      check({tag, ".res"}, alu_result, exp);
      check({tag, ".zero"}, W'(alu_zero), W'(exp == '0));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".res"}, alu_result, '0);
      check({tag, ".zero"}, W'(alu_zero), 32'd1);
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b0;
      sel  = 4'd0;
      op_a = '0;
      op_b = '0;
      @(negedge clk);

      do_reset("reset");
      run_op("add_5_10", 0, 32'd5, 32'd10);
      check("add_5_10.const", alu_result, 32'd15);
      run_op("sub_eq", 1, 32'd10, 32'd10);
      check("sub_eq.const_zero", W'(alu_zero), 32'd1);
      run_op("and", 9, 32'd3, 32'd1);
      run_op("xor", 5, 32'd4, 32'd3);
      check("xor.const", alu_result, 32'd7);
      run_op("or", 8, 32'd4, 32'd5);
      run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1);
      check("add_wrap.const", alu_result, 32'd0);
      run_op("sll", 2, 32'd4, 32'd1);
      run_op("srl", 6, 32'd4, 32'd2);
      run_op("sra_pos", 7, 32'd10, 32'd2);
      run_op("sra_neg", 7, 32'hFFFF_FFF8, 32'd2);
      check("sra_neg.const", alu_result, 32'hFFFF_FFFE);
      run_op("sll_b33", 2, 32'd1, 32'd33);
      check("sll_b33.const", alu_result, 32'd2);
      run_op("srl_31", 6, 32'h8000_0000, 32'd31);
      run_op("sll_0", 2, 32'hDEAD_BEEF, 32'd0);
      run_op("sra_0", 7, 32'h8000_0001, 32'h20);
      run_op("slt_neg", 3, 32'hFFFF_FFEC, 32'd10);
      check("slt_neg.const", alu_result, 32'd1);
      run_op("slt_pos", 3, 32'd10, 32'hFFFF_FFEC);
      run_op("sltu_lt", 4, 32'd3, 32'd5);
      run_op("sltu_gt", 4, 32'd5, 32'd3);
      run_op("sltu_big", 4, 32'hFFFF_FFEC, 32'd10);
      run_op("pass_b", 10, 32'd10, 32'd3);
      check("pass_b.const", alu_result, 32'd3);
      run_op("undef_15", 15, 32'd7, 32'd9);
      run_op("undef_11", 11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Back-to-back stream with a reset injected in the middle.
      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("b2b_%0d", i), i, 32'h1234_5678 + W'(i), 32'h0F0F_0F0F ^ W'(i * 3));
         if (i == 5) begin
            sel  = 4'd0;
            op_a = 32'd5;
            op_b = 32'd10;
            do_reset("mid_reset");
         end
      end

      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] a, b;
         int s;
         s = int'($urandom_range(0, 15));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: b = 32'hFFFF_FFFF;
            2: b = a;
            3: b = b & 32'h3F;
            default: ;
         endcase
         run_op($sformatf("rand_%0d", i), s, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu_core
